// File: rtl/arm_core_pkg.sv
// arm_core_pkg: Thumb-2 width decode constants, fetch-queue FSM states and the 32-bit prefix test.
package arm_core_pkg;
    localparam logic [4:0] T32_PFX0 = 5'b11101;
    localparam logic [4:0] T32_PFX1 = 5'b11110;
    localparam logic [4:0] T32_PFX2 = 5'b11111;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fq_state_e;

    function automatic logic is_thumb32(input logic [15:0] hw);
        return hw[15:11] == T32_PFX0 || hw[15:11] == T32_PFX1 || hw[15:11] == T32_PFX2;
    endfunction
endpackage

// File: rtl/thumb_fetch_queue_hw_fifo.sv
// hw_fifo: DEPTH x 16 circular halfword buffer, push 1 / pop 0..2 per cycle, two-entry head peek.
module hw_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [15:0]              wdata,
    input  logic [1:0]               pop,
    output logic [15:0]              hd0,
    output logic [15:0]              hd1,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rp, wp;

    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;

    always_ff @(posedge clk)
        if (!rst) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            rp    <= clr ? '0 : rp + AW'(pop);
            wp    <= clr ? '0 : wp + AW'(push);
            count <= clr ? '0 : count - CW'(pop) + CW'(push);
        end

    assign hd0 = mem[rp];
    assign hd1 = mem[rp + AW'(1)];
endmodule

// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue: Thumb-2 halfword fetch queue with flush/drain and 16/32-bit instruction assembly.
// Optional THUMB_FQ_STATS_EN adds stat_retired / stat_stall saturating counters.
module thumb_fetch_queue
    import arm_core_pkg::*;
#(
    parameter int                DEPTH      = 8,
    parameter int                ADDR_W     = 32,
    parameter int                MAX_OUTST  = 2,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic              inst_is32,
    output logic [ADDR_W-1:0] inst_pc
`ifdef THUMB_FQ_STATS_EN
    ,
    output logic [31:0]       stat_retired,
    output logic [31:0]       stat_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;

    fq_state_e         state, state_n;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CW-1:0]     count;
    logic [OW-1:0]     outst, drop, drop_n;
    logic [15:0]       hd0, hd1, hw0;
    logic              rv, push, issue;
    logic [1:0]        pop_n;

    hw_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .wdata (mem_rdata),
        .pop   (pop_n),
        .hd0   (hd0),
        .hd1   (hd1),
        .count (count)
    );

    // Head is forced to zero when empty so inst/inst_is32 read 0 out of reset.
    assign hw0        = count != '0 ? hd0 : 16'h0;
    assign inst_is32  = is_thumb32(hw0);
    assign inst_valid = inst_is32 ? count > CW'(1) : count != '0;
    assign inst       = {hw0, inst_is32 && count > CW'(1) ? hd1 : 16'h0};
    assign pop_n      = inst_valid && inst_ready && !flush ? (inst_is32 ? 2'd2 : 2'd1) : 2'd0;

    assign mem_req  = rst && !flush && state != IDLE &&
                      32'(count) + 32'(outst) < DEPTH && 32'(outst) < MAX_OUTST;
    assign mem_addr = fetch_addr;
    assign issue    = mem_req && mem_gnt;
    assign rv       = mem_rvalid && state != IDLE;
    // Stale responses are absorbed by the drop counter; anything after it is fresh data.
    assign push     = rv && !flush && (state == FETCH || drop == '0);

    always_comb begin
        state_n = state;
        drop_n  = drop;
        if (state == IDLE) state_n = FETCH;
        else if (flush) begin
            state_n = outst != '0 ? DRAIN : FETCH;
            drop_n  = outst - OW'(rv);
        end else if (state == DRAIN) begin
            drop_n  = drop - OW'(rv && drop != '0);
            state_n = drop_n == '0 ? FETCH : DRAIN;
        end
    end

    always_ff @(posedge clk)
        if (!rst) begin
            state      <= IDLE;
            fetch_addr <= RESET_ADDR;
            inst_pc    <= RESET_ADDR;
            outst      <= '0;
            drop       <= '0;
        end else begin
            state      <= state_n;
            drop       <= drop_n;
            outst      <= outst + OW'(issue) - OW'(rv);
            fetch_addr <= flush ? flush_addr : fetch_addr + ADDR_W'(issue);
            inst_pc    <= flush ? flush_addr : inst_pc + ADDR_W'(pop_n);
        end

`ifdef THUMB_FQ_STATS_EN
    always_ff @(posedge clk)
        if (!rst) begin
            stat_retired <= '0;
            stat_stall   <= '0;
        end else begin
            if (pop_n != 2'd0 && stat_retired != '1) stat_retired <= stat_retired + 32'd1;
            if (inst_ready && !inst_valid && state == FETCH && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
`endif
endmodule

// File: tb/tb_thumb_fetch_queue.sv
// tb_thumb_fetch_queue: directed scenarios against a queue-level reference model plus literal pins.
module tb_thumb_fetch_queue;
    localparam int DEPTH = 8, ADDR_W = 32, MAX_OUTST = 2;

    logic clk = 0, rst = 0, mem_req, mem_gnt = 0, mem_rvalid = 0, flush = 0;
    logic inst_valid, inst_ready = 0, inst_is32;
    logic [ADDR_W-1:0] mem_addr, flush_addr = '0, inst_pc;
    logic [15:0] mem_rdata = '0;
    logic [31:0] inst;
`ifdef THUMB_FQ_STATS_EN
    logic [31:0] stat_retired, stat_stall;
`endif

    thumb_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush), .flush_addr(flush_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_is32(inst_is32),
        .inst_pc(inst_pc)
`ifdef THUMB_FQ_STATS_EN
        , .stat_retired(stat_retired), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [ADDR_W-1:0] addr; int due; bit stale;} req_t;

    req_t              pend[$];
    logic [15:0]       img [512];
    logic [15:0]       mq[$];
    logic [ADDR_W-1:0] ret_pc[$];
    logic [31:0]       ret_inst[$];
    bit                ret_32[$];
    logic [ADDR_W-1:0] m_pc, m_fa;
    bit                m_idle, m_init;
    int                cyc = 0, lat = 1, errors = 0, checks = 0;

    function automatic bit t32(input logic [15:0] h);
        return h[15:13] == 3'b111 && h[12:11] != 2'b00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: memory drives its response, outputs are checked, then model advances.
    task automatic cycle();
        bit e32, ev, ereq;
        logic [31:0] einst;
        int n;
        @(negedge clk);
        mem_rvalid = 0;
        mem_rdata  = 16'h0;
        if (rst && pend.size() > 0) begin
            if (pend[0].due <= cyc) begin
                mem_rvalid = 1;
                mem_rdata  = img[pend[0].addr[8:0]];
            end
        end
        #1;
        e32   = mq.size() > 0 && t32(mq[0]);
        ev    = e32 ? mq.size() >= 2 : mq.size() >= 1;
        einst = ev ? {mq[0], e32 ? mq[1] : 16'h0} : 32'h0;
        ereq  = rst && !flush && !m_idle && mq.size() + pend.size() < DEPTH && pend.size() < MAX_OUTST;
        if (m_init) begin
            chk("mem_req", mem_req, ereq);
            chk("inst_valid", inst_valid, ev);
            chk("inst_pc", inst_pc, m_pc);
            if (ereq) chk("mem_addr", mem_addr, m_fa);
            if (ev) begin
                chk("inst", inst, einst);
                chk("inst_is32", inst_is32, e32);
            end
        end
        if (rst && !flush && inst_valid && inst_ready) begin
            ret_pc.push_back(inst_pc);
            ret_inst.push_back(inst);
            ret_32.push_back(inst_is32);
        end
        if (!rst) begin
            mq.delete();
            pend.delete();
            m_pc   = '0;
            m_fa   = '0;
            m_idle = 1;
            m_init = 1;
        end else if (flush) begin
            mq.delete();
            m_pc   = flush_addr;
            m_fa   = flush_addr;
            m_idle = 0;
            if (mem_rvalid) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1;
        end else begin
            if (ev && inst_ready) begin
                n = e32 ? 2 : 1;
                repeat (n) void'(mq.pop_front());
                m_pc += ADDR_W'(n);
            end
            if (mem_rvalid) begin
                req_t r = pend.pop_front();
                if (!r.stale) mq.push_back(mem_rdata);
            end
            if (ereq && mem_gnt) begin
                pend.push_back('{m_fa, cyc + lat, 0});
                m_fa++;
            end
            m_idle = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 0;
        flush = 0;
        inst_ready = 0;
        mem_gnt = 1;
        cycle();
        rst = 1;
        ret_pc.delete();
        ret_inst.delete();
        ret_32.delete();
    endtask

    task automatic load_stream();
        for (int i = 0; i < 512; i++) img[i] = 16'hBF00 + 16'(i);
    endtask

    initial begin
        int stall;
        load_stream();
        do_reset();
        do_reset();
        chk("reset mem_req", mem_req, 0);
        chk("reset inst_valid", inst_valid, 0);
        chk("reset inst", inst, 0);
        chk("reset inst_is32", inst_is32, 0);
        chk("reset inst_pc", inst_pc, 0);

        // straight 16-bit stream
        inst_ready = 1;
        run(30);
        chk("stream retired", ret_pc.size(), 27);
        for (int k = 0; k < 8; k++) begin
            chk("stream pc", ret_pc[k], k);
            chk("stream inst", ret_inst[k], {16'hBF00 + 16'(k), 16'h0});
        end
`ifdef THUMB_FQ_STATS_EN
        chk("stat_retired", stat_retired, 27);
`endif

        // mixed widths
        do_reset();
        img[0] = 16'hF000; img[1] = 16'hB800; img[2] = 16'h4608;
        inst_ready = 1;
        run(12);
        chk("mixed pc0", ret_pc[0], 0);
        chk("mixed inst0", ret_inst[0], 32'hF000B800);
        chk("mixed is32_0", ret_32[0], 1);
        chk("mixed pc1", ret_pc[1], 2);
        chk("mixed inst1", ret_inst[1], 32'h46080000);
        chk("mixed is32_1", ret_32[1], 0);

        // split 32-bit with grant stall after hw0
        do_reset();
        img[0] = 16'hE92D; img[1] = 16'h4FF0; img[2] = 16'hBF02;
        inst_ready = 1;
        stall = 0;
        for (int i = 0; i < 25; i++) begin
            mem_gnt = !(m_fa == 1 && stall < 5);
            if (m_fa == 1 && stall < 5) stall++;
            cycle();
        end
        mem_gnt = 1;
        chk("split pc0", ret_pc[0], 0);
        chk("split inst0", ret_inst[0], 32'hE92D4FF0);
        chk("split pc1", ret_pc[1], 2);
        load_stream();

        // backpressure
        do_reset();
        inst_ready = 0;
        run(20);
        chk("bp mem_req", mem_req, 0);
        chk("bp inst_valid", inst_valid, 1);
        chk("bp inst_pc", inst_pc, 0);
        inst_ready = 1;
        run(20);
        for (int k = 0; k < 8; k++) chk("bp pc", ret_pc[k], k);
        chk("bp inst7", ret_inst[7], 32'hBF070000);

        // flush with two outstanding, latency 3
        do_reset();
        lat = 3;
        inst_ready = 1;
        for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
        chk("flush outstanding", pend.size(), 2);
        flush = 1;
        flush_addr = 32'h100;
        cycle();
        flush = 0;
        chk("flush inst_valid", inst_valid, 0);
        chk("flush inst_pc", inst_pc, 32'h100);
        run(15);
        chk("flush first pc", ret_pc[0], 32'h100);
        chk("flush first inst", ret_inst[0], 32'hC0000000);
        chk("flush second pc", ret_pc[1], 32'h101);
        lat = 1;

        // reset mid-fetch with five queued
        do_reset();
        inst_ready = 0;
        for (int i = 0; i < 30 && mq.size() != 5; i++) cycle();
        chk("midreset count", mq.size(), 5);
        rst = 0;
        cycle();
        rst = 1;
        chk("midreset inst_valid", inst_valid, 0);
        chk("midreset mem_req", mem_req, 0);
        chk("midreset inst_pc", inst_pc, 0);
        inst_ready = 1;
        run(10);
        chk("midreset pc0", ret_pc[0], 0);
        chk("midreset inst0", ret_inst[0], 32'hBF000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
